// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA frame-buffer write path.
package vga_pkg;

    localparam int ADDR_BITS = 11;
    localparam int HD        = 1280;
    localparam int VD        = 1024;

    typedef enum logic [1:0] {
        BLACK = 2'd0,
        WHITE = 2'd1,
        BLUE  = 2'd2,
        GREEN = 2'd3
    } color_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0] x;
        logic [ADDR_BITS-1:0] y;
        color_t               color;
    } fb_wr_t;

    function automatic logic in_range(input logic [ADDR_BITS-1:0] x,
                                      input logic [ADDR_BITS-1:0] y,
                                      input int hd, input int vd);
        return (int'(x) < hd) && (int'(y) < vd);
    endfunction

endpackage

// File: rtl/vga_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the pointer only moves on an advance strobe.
module vga_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic               en_i,
    input  logic               adv_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_cand;
    logic [PTR_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_found;
    logic               w_hit;

    // First valid requester at or after the pointer, searching upward with wrap.
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        w_hit   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand         = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
            w_hit          = en_i && !w_found && req_i[w_cand];
            w_gnt[w_cand]  = w_gnt[w_cand] | w_hit;
            w_idx          = w_hit ? w_cand : w_idx;
            w_found        = w_found | w_hit;
        end
    end

    // Pointer register: moves past the winner only when a transfer happens.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            r_ptr <= '0;
        end else if (adv_i) begin
            r_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + PTR_W'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign gnt_o = w_gnt;

endmodule

// File: rtl/vga_fb_write_arbiter.sv
// Frame-buffer write port owner: round-robin sharing between requesters plus a
// full-buffer clear engine. All buffer-side outputs are registered.
module vga_fb_write_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int HD        = vga_pkg::HD,
    parameter int VD        = vga_pkg::VD,
    parameter int ADDR_BITS = vga_pkg::ADDR_BITS
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*ADDR_BITS-1:0] req_x_i,
    input  logic [NUM_REQ*ADDR_BITS-1:0] req_y_i,
    input  logic [NUM_REQ*2-1:0]         req_color_i,
    input  logic                         clear_start_i,
    input  logic [1:0]                   clear_color_i,
    output logic                         we_o,
    output logic [ADDR_BITS-1:0]         addr_x_o,
    output logic [ADDR_BITS-1:0]         addr_y_o,
    output logic [1:0]                   color_o,
    output logic                         busy_o,
    output logic                         clear_done_o,
    output logic                         range_err_o
);
    import vga_pkg::*;

    localparam logic [ADDR_BITS-1:0] X_LAST = ADDR_BITS'(HD - 1);
    localparam logic [ADDR_BITS-1:0] Y_LAST = ADDR_BITS'(VD - 1);

    fb_state_t            r_state;
    fb_state_t            w_state_nxt;
    logic                 r_we;
    logic [ADDR_BITS-1:0] r_x;
    logic [ADDR_BITS-1:0] r_y;
    logic [1:0]           r_color;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_rerr;

    logic [NUM_REQ-1:0]   w_gnt;
    logic                 w_arb_en;
    logic                 w_xfer;
    logic                 w_in_range;
    logic                 w_clr_last;
    fb_wr_t               w_sel;

    // Grants are withheld while clearing, when a clear is being started, and in
    // the done-pulse cycle so the completion is seen before new pixels land.
    assign w_arb_en   = arstn_i && (r_state == ST_IDLE) && !clear_start_i && !r_done;
    assign w_xfer     = |(req_valid_i & w_gnt);
    assign w_clr_last = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_in_range = in_range(w_sel.x, w_sel.y, HD, VD);

    vga_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .en_i    (w_arb_en),
        .adv_i   (w_xfer),
        .req_i   (req_valid_i),
        .gnt_o   (w_gnt)
    );

    // One-hot grant selects the winning requester's coordinates and colour.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel.x     = w_sel.x | (req_x_i[i*ADDR_BITS +: ADDR_BITS] & {ADDR_BITS{w_gnt[i]}});
            w_sel.y     = w_sel.y | (req_y_i[i*ADDR_BITS +: ADDR_BITS] & {ADDR_BITS{w_gnt[i]}});
            w_sel.color = color_t'(w_sel.color | (req_color_i[i*2 +: 2] & {2{w_gnt[i]}}));
        end
    end

    // Next-state logic for the IDLE/CLEAR controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (clear_start_i) begin
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (w_clr_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output registers; r_x/r_y double as the sweep counters, holding the
    // address currently presented on the port.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            r_we    <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rerr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_rerr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clear_start_i) begin
                        r_we    <= 1'b1;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_color <= clear_color_i;
                        r_busy  <= 1'b1;
                    end else if (w_xfer && w_in_range) begin
                        r_we    <= 1'b1;
                        r_x     <= w_sel.x;
                        r_y     <= w_sel.y;
                        r_color <= w_sel.color;
                    end else if (w_xfer) begin
                        r_we    <= 1'b0;
                        r_rerr  <= 1'b1;
                    end else begin
                        r_we    <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (w_clr_last) begin
                        r_we   <= 1'b0;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else if (r_x == X_LAST) begin
                        r_we <= 1'b1;
                        r_x  <= '0;
                        r_y  <= (r_y == Y_LAST) ? '0 : r_y + ADDR_BITS'(1);
                    end else begin
                        r_we <= 1'b1;
                        r_x  <= r_x + ADDR_BITS'(1);
                    end
                end
                default: begin
                    r_we   <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = w_gnt;
    assign we_o         = r_we;
    assign addr_x_o     = r_x;
    assign addr_y_o     = r_y;
    assign color_o      = r_color;
    assign busy_o       = r_busy;
    assign clear_done_o = r_done;
    assign range_err_o  = r_rerr;

endmodule
